// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: input-side packet controller of the router.
// Accepts the serial byte stream, decodes the {len, addr} header, steers
// header/payload/parity bytes into one of three FIFOs, back-pressures the
// source through busy, and flags parity/length errors and wait timeouts.
// Packets addressed to port 3 are consumed and discarded.
module router_pkt_ctrl #(
  parameter int WAIT_LIMIT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  output logic [2:0] wr_en,
  output logic [7:0] d_out,
  output logic       lfd_state,
  output logic       busy,
  output logic       parity_err,
  output logic       len_err,
  output logic       timeout,
  output logic       pkt_done
);

  // Wait counter is sized to hold WAIT_LIMIT; the expiry compare uses the
  // last in-range value so WAIT_EMPTY lasts exactly WAIT_LIMIT cycles.
  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_EMPTY = 3'd1,
    ST_LFD        = 3'd2,
    ST_LOAD_DATA  = 3'd3,
    ST_CHECK      = 3'd4,
    ST_DROP       = 3'd5
  } state_t;

  // Running packet parity: XOR of header and every payload byte.
  function automatic logic [7:0] parity_update(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction

  // One-hot FIFO select; port 3 has no FIFO and maps to no write.
  function automatic logic [2:0] port_onehot(input logic [1:0] addr);
    logic [2:0] sel;
    case (addr)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Per-port flag lookup that stays in range for address 3.
  function automatic logic port_bit(input logic [2:0] vec, input logic [1:0] addr);
    logic bit_v;
    case (addr)
      2'd0:    bit_v = vec[0];
      2'd1:    bit_v = vec[1];
      2'd2:    bit_v = vec[2];
      default: bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      hdr_r;
  logic [7:0]      parity_acc_r;
  logic [7:0]      rx_parity_r;
  logic [5:0]      cnt_r;
  logic [WW-1:0]   wait_cnt_r;
  logic            parity_err_r;
  logic            len_err_r;

  logic [1:0]      hdr_addr_s;
  logic [5:0]      hdr_len_s;
  logic [1:0]      in_addr_s;
  logic            tgt_full_s;
  logic            tgt_empty_s;
  logic            wait_expired_s;
  logic            accept_s;
  logic            load_s;
  logic            capture_parity_s;
  logic            wait_inc_s;
  logic            check_s;

  assign hdr_addr_s     = hdr_r[1:0];
  assign hdr_len_s      = hdr_r[7:2];
  assign in_addr_s      = data_in[1:0];
  assign tgt_full_s     = port_bit(fifo_full, hdr_addr_s);
  assign tgt_empty_s    = port_bit(fifo_empty, hdr_addr_s);
  assign wait_expired_s = (wait_cnt_r == WAIT_LAST);

  assign parity_err = parity_err_r;
  assign len_err    = len_err_r;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the FIFO write port and handshake outputs,
  // which the FIFOs sample on the same edge the state advances.
  always_comb begin
    state_nxt_s      = state_r;
    wr_en            = 3'b000;
    d_out            = 8'h00;
    lfd_state        = 1'b0;
    busy             = 1'b0;
    timeout          = 1'b0;
    pkt_done         = 1'b0;
    accept_s         = 1'b0;
    load_s           = 1'b0;
    capture_parity_s = 1'b0;
    wait_inc_s       = 1'b0;
    check_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pkt_valid) begin
          accept_s = 1'b1;
          if (in_addr_s == 2'd3) begin
            state_nxt_s = ST_DROP;
          end else if (port_bit(fifo_empty, in_addr_s)) begin
            state_nxt_s = ST_LFD;
          end else begin
            state_nxt_s = ST_WAIT_EMPTY;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_EMPTY: begin
        busy = 1'b1;
        // A FIFO draining on the final wait cycle still wins over expiry.
        if (tgt_empty_s) begin
          state_nxt_s = ST_LFD;
        end else if (wait_expired_s) begin
          timeout     = 1'b1;
          state_nxt_s = ST_DROP;
        end else begin
          wait_inc_s  = 1'b1;
        end
      end
      ST_LFD: begin
        // The FIFO was empty, so the header goes in without a full check.
        busy        = 1'b1;
        wr_en       = port_onehot(hdr_addr_s);
        d_out       = hdr_r;
        lfd_state   = 1'b1;
        state_nxt_s = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        busy = tgt_full_s;
        if (!tgt_full_s) begin
          wr_en = port_onehot(hdr_addr_s);
          d_out = data_in;
          if (pkt_valid) begin
            load_s = 1'b1;
          end else begin
            capture_parity_s = 1'b1;
            state_nxt_s      = ST_CHECK;
          end
        end else begin
          state_nxt_s = ST_LOAD_DATA;
        end
      end
      ST_CHECK: begin
        busy        = 1'b1;
        pkt_done    = 1'b1;
        check_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      ST_DROP: begin
        if (!pkt_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Header capture, parity/length accumulation, wait timer and error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_r        <= 8'h00;
      parity_acc_r <= 8'h00;
      rx_parity_r  <= 8'h00;
      cnt_r        <= 6'd0;
      wait_cnt_r   <= '0;
      parity_err_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else if (accept_s) begin
      hdr_r        <= data_in;
      parity_acc_r <= data_in;
      cnt_r        <= 6'd0;
      wait_cnt_r   <= '0;
      parity_err_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else if (wait_inc_s) begin
      wait_cnt_r <= wait_cnt_r + WW'(1);
    end else if (load_s) begin
      parity_acc_r <= parity_update(parity_acc_r, data_in);
      // Saturate so an over-long packet cannot wrap back to a matching length.
      if (cnt_r != 6'd63) begin
        cnt_r <= cnt_r + 6'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (capture_parity_s) begin
      rx_parity_r <= data_in;
    end else if (check_s) begin
      parity_err_r <= (rx_parity_r != parity_acc_r);
      len_err_r    <= (cnt_r != hdr_len_s);
    end else begin
      hdr_r <= hdr_r;
    end
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: packet-level reference model that predicts the
// ordered FIFO writes, error flags, timeout and completion timing of each
// packet from its header, payload and the FIFO flag pattern applied.
module tb_router_pkt_ctrl;
  localparam int WAIT_LIMIT = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] wr_en;
  logic [7:0] d_out;
  logic       lfd_state, busy, parity_err, len_err, timeout, pkt_done;

  router_pkt_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst_n), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .wr_en(wr_en),
    .d_out(d_out), .lfd_state(lfd_state), .busy(busy),
    .parity_err(parity_err), .len_err(len_err), .timeout(timeout),
    .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] we; logic [7:0] d; logic lfd; } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n, lfd_edge, to_edge, done_edge, to_cnt, done_cnt;
  logic s_busy;
  logic prev_perr = 1'b0;
  logic prev_lerr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] port_mask(input logic [1:0] a);
    if (a == 2'd3) return 3'b000;
    return 3'(1 << a);
  endfunction

  function automatic logic [2:0] rand_full();
    logic [2:0] f;
    for (int i = 0; i < 3; i++) f[i] = ($urandom_range(0, 2) == 0);
    return f;
  endfunction

  // One clock: observe outputs mid-cycle, then advance past the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    s_busy = busy;
    if (wr_en != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {29'd0, wr_en}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_en", {29'd0, wr_en}, {29'd0, e.we});
        check_eq("d_out", {24'd0, d_out}, {24'd0, e.d});
        check_eq("lfd_state", {31'd0, lfd_state}, {31'd0, e.lfd});
        if (lfd_state) lfd_edge = edge_n + 1;
      end
    end else if (lfd_state) begin
      check_eq("lfd_without_write", {31'd0, lfd_state}, 32'd0);
    end
    if (!lfd_state && ((wr_en & fifo_full) != 3'b000))
      check_eq("write_while_full", {29'd0, wr_en & fifo_full}, 32'd0);
    if (timeout) begin to_cnt++; to_edge = edge_n + 1; end
    if (pkt_done) begin done_cnt++; done_edge = edge_n + 1; end
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Drive one packet with handshake and predict everything it should cause.
  // hold: number of edges (from header acceptance) the target FIFO reads non-empty.
  // abort_idx >= 0: pull reset once that many bytes have been consumed.
  task automatic send_pkt(input logic [1:0] addr, input int len, input int np,
                          input bit bad, input int hold, input bit stall, input int abort_idx);
    logic [7:0] bytes_q[$];
    logic [7:0] hdr, par, b;
    bit drop, exp_to, aborted;
    int idx;
    hdr = {6'(len), addr};
    par = hdr;
    bytes_q.push_back(hdr);
    for (int i = 0; i < np; i++) begin
      b = 8'($urandom);
      par ^= b;
      bytes_q.push_back(b);
    end
    if (bad) par ^= 8'($urandom_range(1, 255));
    bytes_q.push_back(par);
    drop    = (addr == 2'd3) || (hold > WAIT_LIMIT);
    exp_to  = (addr != 2'd3) && (hold > WAIT_LIMIT);
    aborted = 1'b0;
    if (!drop)
      for (int i = 0; i < bytes_q.size(); i++)
        if (abort_idx < 0 || i < abort_idx)
          exp_q.push_back('{we: port_mask(addr), d: bytes_q[i], lfd: (i == 0)});
    check_eq("err_hold", {30'd0, parity_err, len_err}, {30'd0, prev_perr, prev_lerr});
    to_cnt = 0; done_cnt = 0; lfd_edge = -1; to_edge = -1; done_edge = -1;
    edge_n = -1; idx = 0;
    fifo_empty = (hold > 0) ? ~port_mask(addr) : 3'b111;
    while (idx < bytes_q.size()) begin
      if (abort_idx >= 0 && idx == abort_idx) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_outputs",
                 {14'd0, wr_en, d_out, lfd_state, busy, parity_err, len_err, timeout, pkt_done}, 32'd0);
        check_eq("abort_writes", exp_q.size(), 32'd0);
        pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (edge_n > 3000) begin
        check_eq("pkt_stuck", idx, bytes_q.size());
        break;
      end
      data_in   = bytes_q[idx];
      pkt_valid = (idx != bytes_q.size() - 1);
      fifo_full = (stall && edge_n >= 0) ? rand_full() : 3'b000;
      if (edge_n + 1 >= hold) fifo_empty = 3'b111;
      tick();
      if (!s_busy) idx++;
      if (edge_n == 0) check_eq("err_clear", {30'd0, parity_err, len_err}, 32'd0);
      if (addr == 2'd3) check_eq("drop_busy", {31'd0, s_busy}, 32'd0);
    end
    pkt_valid = 1'b0;
    fifo_full = 3'b000;
    if (aborted) begin
      prev_perr = 1'b0; prev_lerr = 1'b0;
    end else if (!drop) begin
      for (int w = 0; w < 4 && done_cnt == 0; w++) tick();
      check_eq("done_count", done_cnt, 32'd1);
      check_eq("parity_err", {31'd0, parity_err}, {31'd0, bad});
      check_eq("len_err", {31'd0, len_err}, {31'd0, (np != len)});
      check_eq("hdr_edge", lfd_edge, hold + 1);
      if (!stall) check_eq("done_edge", done_edge, hold + np + 3);
      check_eq("writes_left", exp_q.size(), 32'd0);
      prev_perr = bad; prev_lerr = (np != len);
    end else begin
      check_eq("drop_done", done_cnt, 32'd0);
      check_eq("timeout_count", to_cnt, {31'd0, exp_to});
      if (exp_to) check_eq("timeout_edge", to_edge, WAIT_LIMIT);
      check_eq("drop_writes", exp_q.size(), 32'd0);
      prev_perr = 1'b0; prev_lerr = 1'b0;
    end
  endtask

  // Directed corner cases followed by randomized packet traffic.
  initial begin
    int len, np, r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state",
             {14'd0, wr_en, d_out, lfd_state, busy, parity_err, len_err, timeout, pkt_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_quiet", {18'd0, wr_en, d_out, lfd_state, busy, timeout, pkt_done}, 32'd0);

    send_pkt(2'd1, 3, 3, 1'b0, 0, 1'b0, -1);   // clean packet to port 1
    send_pkt(2'd1, 3, 3, 1'b1, 0, 1'b0, -1);   // bad parity
    send_pkt(2'd1, 3, 3, 1'b0, 0, 1'b0, -1);   // flags cleared by next header
    send_pkt(2'd2, 2, 2, 1'b0, 0, 1'b1, -1);   // stalls on full
    send_pkt(2'd3, 1, 1, 1'b0, 0, 1'b0, -1);   // dropped port 3
    send_pkt(2'd0, 1, 1, 1'b0, 40, 1'b0, -1);  // wait timeout
    send_pkt(2'd0, 1, 1, 1'b0, 5, 1'b0, -1);   // FIFO drains early
    send_pkt(2'd0, 2, 2, 1'b0, WAIT_LIMIT, 1'b0, -1);
    send_pkt(2'd0, 2, 2, 1'b0, WAIT_LIMIT + 1, 1'b0, -1);
    send_pkt(2'd1, 0, 0, 1'b0, 0, 1'b0, -1);   // zero-length packet
    send_pkt(2'd2, 4, 3, 1'b0, 0, 1'b0, -1);   // short packet
    send_pkt(2'd2, 4, 5, 1'b0, 0, 1'b0, -1);   // long packet
    send_pkt(2'd1, 5, 5, 1'b0, 0, 1'b0, 3);    // reset after 2 payloads
    send_pkt(2'd1, 5, 5, 1'b0, 0, 1'b0, -1);   // fresh packet after reset
    send_pkt(2'd0, 63, 63, 1'b0, 0, 1'b1, -1); // maximum length

    for (int p = 0; p < 150; p++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 10);
      np  = len;
      r   = $urandom_range(0, 5);
      if (r == 0 && len < 63) np = len + 1;
      if (r == 1 && len > 0) np = len - 1;
      send_pkt(2'($urandom_range(0, 3)), len, np, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : 0,
               1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/router_pkt_ctrl.md
# router_pkt_ctrl

Packet input controller for the router: accepts the serial byte stream from the router input port, decodes the header, and writes header, payload and parity bytes into the addressed one of three `router_fifo` instances. It drives each FIFO's write enable, data and `lfd_state`, and back-pressures the source with `busy`. It checks packet parity and length, and drops packets addressed to port 3.

## Interface
- `WAIT_LIMIT`, default 30: number of consecutive cycles in WAIT_EMPTY before the packet is dropped.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: high for header and payload bytes; low on the parity byte.
- `data_in` in 8: packet byte. Header is {len[7:2], addr[1:0]}.
- `fifo_full` in 3: full flag of FIFO 0/1/2.
- `fifo_empty` in 3: empty flag of FIFO 0/1/2.
- `wr_en` out 3: one-hot write enable to the addressed FIFO.
- `d_out` out 8: write data, shared by all FIFOs.
- `lfd_state` out 1: high only during the header write.
- `busy` out 1: source must hold `data_in`/`pkt_valid` stable while high.
- `parity_err` out 1: received parity ≠ computed parity, registered.
- `len_err` out 1: payload count ≠ len, registered.
- `timeout` out 1: one-cycle pulse when WAIT_EMPTY expires.
- `pkt_done` out 1: one-cycle pulse in CHECK.

## Operation
- Packet format: header, len payload bytes (len 0..63, 0 legal), parity byte. Parity is the XOR of the header and all payload bytes.
- A byte is consumed at every rising edge where `busy`=0. The exception is that LFD and CHECK never consume a byte.
- IDLE: `busy`=0, no writes. On `pkt_valid`=1:
  - latch the header into hdr_reg; parity_acc ← header; cnt ← 0;
  - clear `parity_err` and `len_err`;
  - addr=3 → DROP; otherwise `fifo_empty`[addr]=1 → LFD, else → WAIT_EMPTY.
- WAIT_EMPTY: `busy`=1, wait counter increments each cycle.
  - `fifo_empty`[addr]=1 → LFD.
  - Counter reaches WAIT_LIMIT → pulse `timeout` and go to DROP. The held byte is not consumed at this transition; it is consumed by DROP.
- LFD: `busy`=1. `wr_en`[addr]=1, `d_out`=hdr_reg, `lfd_state`=1. Always → LOAD_DATA. The header is written unconditionally because the FIFO was empty.
- LOAD_DATA: `busy`=`fifo_full`[addr] (combinational). When `fifo_full`[addr]=0:
  - `wr_en`[addr]=1 and `d_out`=`data_in`.
  - If `pkt_valid`=1: parity_acc ^= `data_in`; cnt++ (6-bit, saturates at 63). Stay in LOAD_DATA.
  - If `pkt_valid`=0: latch rx_parity ← `data_in`; → CHECK. The parity byte is also written to the FIFO.
- When `fifo_full`[addr]=1: no write, no consume, stay in LOAD_DATA.
- CHECK: `busy`=1, `pkt_done`=1.
  - `parity_err` ← (rx_parity ≠ parity_acc); `len_err` ← (cnt ≠ len).
  - → IDLE. Error flags hold until the next header is accepted.
- DROP: `busy`=0, no writes. Consume bytes while `pkt_valid`=1. The first consumed byte with `pkt_valid`=0 (the parity byte) → IDLE.
- `wr_en` is zero for non-addressed ports in all states and all-zero outside LFD/LOAD_DATA.

## Timing
- Reset values: state=IDLE; `wr_en`=0, `d_out`=0, `lfd_state`=0, `busy`=0, `parity_err`=0, `len_err`=0, `timeout`=0, `pkt_done`=0; all internal registers 0.
- Reset mid-packet: immediate return to IDLE with no further writes. Source resynchronisation is the upstream block's concern.
- `wr_en`, `d_out`, `lfd_state` are combinational from state, hdr_reg, `data_in` and `fifo_full`; the FIFO samples them on the same edge.
- Latency with the destination FIFO empty and never full:
  - header accepted at edge 0, header written at edge 1;
  - payload k written at edge k+2, parity at edge len+2;
  - `pkt_done` at edge len+3; next header accepted at edge len+4.
- `fifo_full` rising while the parity byte is presented: the parity write is held, exactly like a payload stall.
- `pkt_valid` dropping in IDLE while no packet is active has no effect.

## Test plan
- Header 0x0D (len 3, addr 1), payload 0x11/0x22/0x33, parity 0x0D^0x11^0x22^0x33=0x0D → `wr_en`=3'b010 for 5 consecutive writes, `lfd_state` only on the first, `parity_err`=0, `len_err`=0, `pkt_done` once.
- Same packet with parity 0xFF → `parity_err`=1 after CHECK, cleared at the next accepted header.
- Header 0x0A (len 2, addr 2), `fifo_full`[2] asserted for 4 cycles after the first payload → `busy`=1 and no write for 4 cycles, second payload written afterwards, no byte lost or duplicated.
- Header 0x07 (addr 3, len 1) → `wr_en`=0 throughout, `busy`=0, return to IDLE after the parity byte, next packet processed normally.
- Header 0x04 (addr 0) with `fifo_empty`[0]=0 for 40 cycles → `timeout` pulse at cycle 30, packet dropped with no writes; same stimulus with empty asserted at cycle 5 → header written at cycle 6.
- `rst` low during LOAD_DATA after 2 of 5 payloads → all outputs 0 immediately, state IDLE, and a fresh packet after release completes correctly.
